// File: rtl/alsu_param.sv
// alsu_param: two-stage pipelined arithmetic/logic/shift unit.
//   Stage 1 captures the operands and controls whenever in_valid is high.
//   Stage 2 evaluates the captured operation and updates out/leds/err_count.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   A, B                  WIDTH-bit operands
//   op                    3-bit opcode
//   cin, serial_in        carry-in, shift-in bit
//   direction             shift/rotate direction (1 = left)
//   red_op_A, red_op_B    reduction operand selects (op 000/001 only)
//   bypass_A, bypass_B    pass an operand straight to out
//   in_valid              qualifies all inputs this cycle
//   out                   2*WIDTH-bit registered result
//   out_valid             one-cycle pulse when out updates
//   leds                  invalid-operation indicator (toggles per invalid op)
//   err_count             saturating count of invalid operations
module alsu_param #(
  parameter int WIDTH          = 3,
  parameter     INPUT_PRIORITY = "A",
  parameter     FULL_ADDER     = "ON",
  parameter int ERR_CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       A,
  input  logic [WIDTH-1:0]       B,
  input  logic [2:0]             op,
  input  logic                   cin,
  input  logic                   serial_in,
  input  logic                   direction,
  input  logic                   red_op_A,
  input  logic                   red_op_B,
  input  logic                   bypass_A,
  input  logic                   bypass_B,
  input  logic                   in_valid,
  output logic [2*WIDTH-1:0]     out,
  output logic                   out_valid,
  output logic [15:0]            leds,
  output logic [ERR_CNT_W-1:0]   err_count
);

  localparam int unsigned OW      = 2 * WIDTH;
  localparam bit          PRI_A   = (INPUT_PRIORITY == "A");
  localparam bit          ADD_CIN = (FULL_ADDER == "ON");

  // Stage 1 registers
  logic [WIDTH-1:0] r_a, r_b;
  logic [2:0]       r_op;
  logic             r_cin, r_sin, r_dir, r_ra, r_rb, r_ba, r_bb, r_v;

  // Stage 2 combinational evaluation
  logic [OW-1:0]    w_res;
  logic             w_bypass, w_invalid, w_byp_use_a, w_red_use_a, w_red;

  // Stage 1: capture on in_valid, otherwise hold data and mark empty
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= '0;
      r_cin <= 1'b0;
      r_sin <= 1'b0;
      r_dir <= 1'b0;
      r_ra  <= 1'b0;
      r_rb  <= 1'b0;
      r_ba  <= 1'b0;
      r_bb  <= 1'b0;
      r_v   <= 1'b0;
    end else begin
      r_v <= in_valid;
      if (in_valid) begin
        r_a   <= A;
        r_b   <= B;
        r_op  <= op;
        r_cin <= cin;
        r_sin <= serial_in;
        r_dir <= direction;
        r_ra  <= red_op_A;
        r_rb  <= red_op_B;
        r_ba  <= bypass_A;
        r_bb  <= bypass_B;
      end
    end
  end

  // Result selection: bypass beats invalid check beats opcode
  always_comb begin
    w_bypass    = r_ba | r_bb;
    w_red       = r_ra | r_rb;
    w_invalid   = (r_op[2:1] == 2'b11) || (w_red && (r_op[2:1] != 2'b00));
    // Single flag picks its own operand; both flags defer to INPUT_PRIORITY
    w_byp_use_a = r_ba & (~r_bb | PRI_A);
    w_red_use_a = r_ra & (~r_rb | PRI_A);
    w_res       = '0;

    case (r_op)
      3'b000: w_res = w_red ? OW'(w_red_use_a ? &r_a : &r_b) : OW'(r_a & r_b);
      3'b001: w_res = w_red ? OW'(w_red_use_a ? ^r_a : ^r_b) : OW'(r_a ^ r_b);
      3'b010: w_res = OW'(r_a) + OW'(r_b) + OW'(ADD_CIN & r_cin);
      3'b011: w_res = OW'(r_a) * OW'(r_b);
      // Shift/rotate act on the current out register so chained ops compose
      3'b100: w_res = r_dir ? {out[OW-2:0], r_sin} : {r_sin, out[OW-1:1]};
      3'b101: w_res = r_dir ? {out[OW-2:0], out[OW-1]} : {out[0], out[OW-1:1]};
      default: w_res = '0;
    endcase

    if (w_bypass) begin
      w_res = OW'(w_byp_use_a ? r_a : r_b);
    end else if (w_invalid) begin
      w_res = '0;
    end
  end

  // Stage 2: registered outputs, updated only for a valid stage-1 entry
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      leds      <= '0;
      err_count <= '0;
    end else begin
      out_valid <= r_v;
      if (r_v) begin
        out <= w_res;
        if (!w_bypass && w_invalid) begin
          leds <= ~leds;
          if (err_count != '1) begin
            err_count <= err_count + ERR_CNT_W'(1);
          end
        end else begin
          leds <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alsu_param.sv
// Self-checking bench for alsu_param (default parameters, WIDTH=3).
module tb_alsu_param;

  localparam int W  = 3;
  localparam int OW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  A = '0, B = '0;
  logic [2:0]    op = '0;
  logic          cin = 0, serial_in = 0, direction = 0;
  logic          red_op_A = 0, red_op_B = 0, bypass_A = 0, bypass_B = 0;
  logic          in_valid = 0;
  logic [OW-1:0] out;
  logic          out_valid;
  logic [15:0]   leds;
  logic [7:0]    err_count;

  alsu_param dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .op(op), .cin(cin),
    .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_A), .red_op_B(red_op_B),
    .bypass_A(bypass_A), .bypass_B(bypass_B), .in_valid(in_valid),
    .out(out), .out_valid(out_valid), .leds(leds), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          due;
    int          out;
    logic [15:0] leds;
    int          err;
  } exp_t;

  exp_t q[$];
  bit   rst_at[int];

  // Reference state advanced in issue order
  int          m_out  = 0;
  logic [15:0] m_leds = '0;
  int          m_err  = 0;

  // Currently visible expected outputs
  int          e_out  = 0;
  logic [15:0] e_leds = '0;
  int          e_err  = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, got, exp);
    end
  endtask

  // Per-cycle comparison against the reference
  always @(negedge clk) begin
    bit exp_v;
    exp_v = 1'b0;
    if (rst_at.exists(cyc)) begin
      if (q.size() != 0 && q[0].due == cyc) void'(q.pop_front());
      e_out = 0; e_leds = '0; e_err = 0;
    end else if (q.size() != 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      e_out = e.out; e_leds = e.leds; e_err = e.err;
      exp_v = 1'b1;
    end
    chk("cmp_out_valid", longint'(out_valid), longint'(exp_v));
    chk("cmp_out", longint'(out), longint'(e_out));
    chk("cmp_leds", longint'(leds), longint'(e_leds));
    chk("cmp_err", longint'(err_count), longint'(e_err));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    A = W'($urandom); B = W'($urandom); op = 3'($urandom);
    cin = 1'($urandom); serial_in = 1'($urandom); direction = 1'($urandom);
    red_op_A = 1'($urandom); red_op_B = 1'($urandom);
    bypass_A = 1'($urandom); bypass_B = 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rst = 0; in_valid = 0;
      scramble();
      step();
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rst = 1;
      in_valid = 1'($urandom);
      scramble();
      rst_at[cyc + 1] = 1'b1;
      m_out = 0; m_leds = '0; m_err = 0;
      step();
    end
  endtask

  // Drive one operation and compute its expected result from the rules
  task automatic issue(input int a, input int b, input int opc,
                       input bit c, input bit si, input bit dir,
                       input bit ra, input bit rb, input bit ba, input bit bb);
    int   r;
    bit   inv;
    exp_t e;
    rst = 0; in_valid = 1;
    A = W'(a); B = W'(b); op = 3'(opc); cin = c; serial_in = si; direction = dir;
    red_op_A = ra; red_op_B = rb; bypass_A = ba; bypass_B = bb;

    inv = (opc >= 6) || ((ra || rb) && opc > 1);
    r = 0;
    if (ba || bb) begin
      r = ba ? a : b;
      m_leds = '0;
    end else if (inv) begin
      r = 0;
      m_leds = ~m_leds;
      if (m_err < 255) m_err++;
    end else begin
      m_leds = '0;
      case (opc)
        0: r = (ra || rb) ? ((ra ? a : b) == 7 ? 1 : 0) : (a & b);
        1: r = (ra || rb) ? ($countones(ra ? a : b) % 2) : (a ^ b);
        2: r = a + b + c;
        3: r = a * b;
        4: r = dir ? ((m_out * 2 + si) % 64) : (m_out / 2 + si * 32);
        5: r = dir ? ((m_out * 2) % 64 + m_out / 32) : (m_out / 2 + (m_out % 2) * 32);
        default: r = 0;
      endcase
    end
    m_out = r;
    e.due = cyc + 2; e.out = m_out; e.leds = m_leds; e.err = m_err;
    q.push_back(e);
    step();
  endtask

  initial begin
    rst_at[1] = 1'b1;
    step();
    do_reset(1);
    idle(1);
    chk("reset_out", longint'(out), 0);
    chk("reset_valid", longint'(out_valid), 0);

    // 3+5+cin
    issue(3, 5, 2, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("add_out", longint'(out), 9);
    chk("add_valid", longint'(out_valid), 1);
    idle(1);
    chk("add_valid_drop", longint'(out_valid), 0);

    // 7*7
    issue(7, 7, 3, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("mul_out", longint'(out), 49);

    // reduction AND then two invalid ops
    issue(7, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(1);
    chk("redand_out", longint'(out), 1);
    issue(1, 1, 2, 0, 0, 0, 1, 0, 0, 0);
    idle(1);
    chk("inv1_out", longint'(out), 0);
    chk("inv1_leds", longint'(leds), 'hFFFF);
    issue(1, 1, 2, 0, 0, 0, 1, 0, 0, 0);
    idle(1);
    chk("inv2_leds", longint'(leds), 0);
    chk("inv2_err", longint'(err_count), 2);

    // back-to-back: set 000001, shift left in 1, rotate right
    issue(7, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    issue(0, 0, 4, 0, 1, 1, 0, 0, 0, 0);
    issue(0, 0, 5, 0, 1, 0, 0, 0, 0, 0);
    idle(1);
    chk("rot_out", longint'(out), 'b100001);

    // both bypass with an invalid opcode
    issue(2, 5, 6, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    chk("byp_out", longint'(out), 2);
    chk("byp_leds", longint'(leds), 0);
    chk("byp_err", longint'(err_count), 2);

    // reset one cycle after in_valid discards the operation
    issue(3, 5, 2, 1, 0, 0, 0, 0, 0, 0);
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      chk("rst_flush_out", longint'(out), 0);
      chk("rst_flush_valid", longint'(out_valid), 0);
      idle(1);
    end

    // error counter saturation
    for (int i = 0; i < 260; i++) issue(0, 0, 7, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    chk("err_sat", longint'(err_count), 255);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int k;
      k = int'($urandom_range(0, 99));
      if (k < 2) do_reset(1);
      else if (k < 72)
        issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      else idle(1);
    end
    idle(3);
    chk("queue_drained", longint'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alsu_param.md
ALSU_PARAM -- requirements
Module: alsu_param

Interface
REQ-001 Parameter WIDTH, default 3: bit width of operands A and B; legal range 2..16.
REQ-002 Parameter INPUT_PRIORITY, default "A": operand chosen when both bypass flags or both reduction flags are set; legal values "A" or "B".
REQ-003 Parameter FULL_ADDER, default "ON": "ON" adds cin into op 010; "OFF" ignores cin.
REQ-004 Parameter ERR_CNT_W, default 8: width of the saturating invalid-operation counter.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 A, B  input  WIDTH each  operands.
REQ-009 op  input  3  opcode.
REQ-010 cin, serial_in, direction  input  1 each  carry in, shift-in bit, shift direction (1 = left).
REQ-011 red_op_A, red_op_B, bypass_A, bypass_B  input  1 each  reduction and bypass selects.
REQ-012 in_valid  input  1  qualifies all data and control inputs this cycle.
REQ-013 out  output  2*WIDTH  registered result.
REQ-014 out_valid  output  1  one-cycle pulse when out updates.
REQ-015 leds  output  16  invalid-operation indicator.
REQ-016 err_count  output  ERR_CNT_W  count of invalid operations.

Function
REQ-017 Stage 1 SHALL capture all inputs on a clk edge with in_valid=1; with in_valid=0 it holds its contents and marks itself empty.
REQ-018 Stage 2 SHALL update out, leds and err_count only when stage 1 holds a valid operation; latency is exactly 2 cycles from in_valid to out_valid; one operation is accepted per cycle with no stalls.
REQ-019 Evaluation priority, highest first: bypass, invalid check, opcode.
REQ-020 bypass_A only -> out=A; bypass_B only -> out=B; both set -> operand per INPUT_PRIORITY; all values zero-extended.
REQ-021 An operation is invalid if op is 110 or 111, or if (red_op_A or red_op_B) is set with op other than 000/001.
REQ-022 op 000: reduction AND (&A or &B; both flags -> INPUT_PRIORITY); no flag -> A&B.
REQ-023 op 001: same selection rules as op 000 using XOR.
REQ-024 op 010: A+B(+cin when FULL_ADDER="ON"), zero-extended to 2*WIDTH, no overflow.
REQ-025 op 011: A*B, unsigned, 2*WIDTH bits.
REQ-026 op 100: shifts the current out register; direction=1 -> {out[2W-2:0],serial_in}; direction=0 -> {serial_in,out[2W-1:1]}.
REQ-027 op 101: rotates the current out register by 1 in the given direction; serial_in is ignored.
REQ-028 On an invalid operation: out <= 0, leds <= ~leds, and err_count increments, saturating at all-ones.
REQ-029 On a valid or bypass operation: leds <= 0 and err_count is unchanged.
REQ-030 With no operation in stage 2: out, leds and err_count hold, and out_valid=0.
REQ-031 Back-to-back shift/rotate operations SHALL each act on the out value produced by the preceding operation.

Reset
REQ-032 On rst=1 at a clk edge: out=0, out_valid=0, leds=0, err_count=0, and both stages empty; in-flight operations are discarded.
REQ-033 rst takes priority over in_valid in the same cycle; that input is not accepted.
REQ-034 The first operation accepted after rst deasserts produces out_valid exactly 2 cycles later.

Verification (WIDTH=3, defaults)
REQ-035 A=3, B=5, op=010, cin=1, in_valid pulsed -> out=9 and out_valid=1 exactly 2 cycles later, out_valid=0 on the next cycle.
REQ-036 A=7, B=7, op=011 -> out=49 (110001).
REQ-037 red_op_A=1, op=000, A=7 -> out=1; then red_op_A=1, op=010 (twice) -> out=0, leds=FFFF then 0000, err_count=2.
REQ-038 out=000001, op=100, direction=1, serial_in=1 -> out=000011; then op=101, direction=0 -> out=100001.
REQ-039 bypass_A=bypass_B=1, A=2, B=5, op=110 -> out=2, leds=0, err_count unchanged.
REQ-040 rst asserted 1 cycle after in_valid -> out=0 and out_valid stays 0 for the following 3 cycles.
